// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : Y86-64 memory stage (8-byte little-endian data memory) + M->W pipeline register
// Revision : 1.0
// ============================================================================
module mem_wb_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int          c_AW       = $clog2(MEM_BYTES);
    localparam logic [63:0] c_MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [2:0]  c_STAT_AOK = 3'd1;
    localparam logic [2:0]  c_STAT_ADR = 3'd3;
    localparam logic [3:0]  c_I_NOP    = 4'h1;
    localparam logic [3:0]  c_I_RMMOVQ = 4'h4;
    localparam logic [3:0]  c_I_MRMOVQ = 4'h5;
    localparam logic [3:0]  c_I_CALL   = 4'h8;
    localparam logic [3:0]  c_I_RET    = 4'h9;
    localparam logic [3:0]  c_I_PUSHQ  = 4'hA;
    localparam logic [3:0]  c_I_POPQ   = 4'hB;
    localparam logic [3:0]  c_REG_NONE = 4'hF;

    logic [7:0]      r_mem [MEM_BYTES];

    logic            w_rd;
    logic            w_wr;
    logic            w_bad;
    logic            w_dmem_err;
    logic            w_commit;
    logic [63:0]     w_addr;
    logic [63:0]     w_rdata;
    logic [c_AW-1:0] w_idx;

    logic [2:0]      r_W_stat;
    logic [3:0]      r_W_icode;
    logic [63:0]     r_W_valE;
    logic [63:0]     r_W_valM;
    logic [3:0]      r_W_dstE;
    logic [3:0]      r_W_dstM;

    // Address is don't-care for non-accessing icodes; valE is used then.
    always_comb begin
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_addr = M_valE;
        case (M_icode)
            c_I_RMMOVQ, c_I_PUSHQ, c_I_CALL: w_wr = 1'b1;
            c_I_MRMOVQ:                      w_rd = 1'b1;
            c_I_POPQ, c_I_RET: begin
                w_rd   = 1'b1;
                w_addr = M_valA;
            end
            default: ;
        endcase
    end

    // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
    assign w_bad      = (w_addr > c_MAX_ADDR);
    assign w_dmem_err = (w_rd | w_wr) & w_bad;
    assign w_idx      = w_addr[c_AW-1:0];
    assign w_commit   = rst_n & w_wr & ~w_bad & (M_stat == c_STAT_AOK) & ~W_stall;

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            w_rdata[8*k +: 8] = r_mem[w_idx + c_AW'(k)];
        end
    end

    assign m_valM = (w_rd & ~w_bad) ? w_rdata : 64'd0;
    assign m_stat = w_dmem_err ? c_STAT_ADR : M_stat;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[w_idx + c_AW'(k)] <= M_valA[8*k +: 8];
            end
        end
    end

    // Stall outranks bubble; reset loads the bubble asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_W_stat  <= c_STAT_AOK;
            r_W_icode <= c_I_NOP;
            r_W_valE  <= '0;
            r_W_valM  <= '0;
            r_W_dstE  <= c_REG_NONE;
            r_W_dstM  <= c_REG_NONE;
        end else if (W_stall) begin
            r_W_stat  <= r_W_stat;
            r_W_icode <= r_W_icode;
            r_W_valE  <= r_W_valE;
            r_W_valM  <= r_W_valM;
            r_W_dstE  <= r_W_dstE;
            r_W_dstM  <= r_W_dstM;
        end else if (W_bubble) begin
            r_W_stat  <= c_STAT_AOK;
            r_W_icode <= c_I_NOP;
            r_W_valE  <= '0;
            r_W_valM  <= '0;
            r_W_dstE  <= c_REG_NONE;
            r_W_dstM  <= c_REG_NONE;
        end else begin
            r_W_stat  <= m_stat;
            r_W_icode <= M_icode;
            r_W_valE  <= M_valE;
            r_W_valM  <= m_valM;
            r_W_dstE  <= M_dstE;
            r_W_dstM  <= M_dstM;
        end
    end

    assign W_stat  = r_W_stat;
    assign W_icode = r_W_icode;
    assign W_valE  = r_W_valE;
    assign W_valM  = r_W_valM;
    assign W_dstE  = r_W_dstE;
    assign W_dstM  = r_W_dstM;

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory stage of the 5-stage pipelined Y86-64 processor, with the M→W pipeline register. It takes the instruction held in the M register and performs the data-memory read or write for that instruction. It computes the stage status and registers the results into the W pipeline register, which feeds the write-back stage that updates the register file. It also exports the combinational `m_valM`/`m_stat` used by forwarding and pipeline control.

## Interface
Parameters:
- `MEM_BYTES`, 1024: data memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `M_stat` in 3: status of the instruction in M. Encoding: AOK=1, HLT=2, ADR=3, INS=4.
- `M_icode` in 4: opcode of the instruction in M. Encoding: halt=0, nop=1, rrmovq=2, irmovq=3, rmmovq=4, mrmovq=5, OPq=6, jXX=7, call=8, ret=9, pushq=A, popq=B.
- `M_valE` in 64: ALU result.
- `M_valA` in 64: operand A; carries the return address for `call`, selected upstream.
- `M_dstE` in 4: destination register for valE; F = none.
- `M_dstM` in 4: destination register for valM; F = none.
- `W_stall` in 1: hold the W register.
- `W_bubble` in 1: load a nop into the W register.
- `m_valM` out 64: combinational memory read data.
- `m_stat` out 3: combinational stage status.
- `W_stat` out 3: registered status.
- `W_icode` out 4: registered opcode.
- `W_valE` out 64: registered valE.
- `W_valM` out 64: registered valM.
- `W_dstE` out 4: registered dstE.
- `W_dstM` out 4: registered dstM.

## Operation
Address select (mem_addr):
- M_valE for rmmovq, pushq, call, mrmovq.
- M_valA for popq, ret.
- Otherwise don't-care.

Memory access type:
- Read for mrmovq, popq, ret.
- Write for rmmovq, pushq, call; write data is M_valA.
- Every other icode performs no access.

Access rules:
- Accesses are 8 bytes, little-endian: byte at mem_addr is bits [7:0]; mem_addr+7 is bits [63:56].
- An address is invalid when mem_addr > MEM_BYTES-8.
- The comparison uses the full 64-bit unsigned value, with no wrap-around. For example, 0xFFFF_FFFF_FFFF_FFFC is invalid.
- dmem_error = (read or write) and address invalid.

m_valM:
- On a valid read, the assembled 8 bytes.
- On an invalid read or no read, 0.

m_stat:
- ADR if dmem_error.
- Otherwise M_stat.

Write commit:
- Occurs at the rising edge only when write, address valid, M_stat == AOK, and W_stall == 0.
- A stalled store writes once, in the cycle it advances.
- A faulting or non-AOK instruction never modifies memory.

The memory array is not reset; its contents are undefined until written.

W register update at each rising edge, in priority order:
1. W_stall=1: all W outputs hold. This takes priority over W_bubble.
2. W_bubble=1: load the bubble. W_icode=1 (nop), W_stat=AOK, W_dstE=W_dstM=F, W_valE=W_valM=0.
3. Otherwise: W_stat←m_stat, W_icode←M_icode, W_valE←M_valE, W_valM←m_valM, W_dstE←M_dstE, W_dstM←M_dstM.

Reset (rst_n=0, asynchronous, at any time including mid-stall):
- W outputs are forced immediately to the bubble values.
- The values hold while rst_n=0; no memory write occurs.
- On the first rising edge after rst_n rises, normal update resumes.

## Timing
- m_valM and m_stat are combinational from M_* inputs and memory contents, settling within the same cycle.
- Load latency: M-stage cycle n → W_valM valid after edge n+1.
- A store committed at edge n is visible to a read in the cycle after edge n, i.e. to the instruction in M after that edge. This gives store→load back-to-back correctness.
- No same-cycle read/write conflict is possible, since one instruction occupies M per cycle.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle with arbitrary inputs → W_icode=1, W_stat=1, W_dstE=W_dstM=F, W_valE=W_valM=0 immediately, before any edge.
- **Store then load:** rmmovq (icode 4) with valE=0x10, valA=0x1122334455667788, then mrmovq (icode 5) with valE=0x10, dstM=3.
  - Required: W_valM=0x1122334455667788, W_dstM=3, W_stat=AOK.
  - Byte 0x10 reads as 0x88.
- **Stack ops:**
  - pushq (A) with valE=0x3F8, valA=5; then popq (B) with valA=0x3F8 → W_valM=5.
  - call (8) with valE=0x3F0, valA=0x40; then ret (9) with valA=0x3F0 → m_valM=0x40.
- **Address fault:** mrmovq with valE=MEM_BYTES-7 → m_stat=3, W_stat=3, W_valM=0. A rmmovq to the same address leaves memory unchanged: a re-read at MEM_BYTES-8 returns its prior value.
- **Stall/bubble:**
  - Hold W_stall=1 for 3 cycles with a store in M → W outputs frozen and exactly one write after release.
  - W_bubble=1 → W_icode=1, W_dstE=F.
  - W_stall=W_bubble=1 → hold.
- **Non-AOK passthrough:** M_stat=HLT with icode 0 → W_stat=2 and no memory change. An OPq (6) with valE=7, dstE=2 → W_valE=7, W_dstE=2, W_valM=0.
